wb_host_master: RTL and testbench

- Wishbone classic initiator that drives the slave-side Wishbone port of the user project (wbs_* signals) from a simple command/data stream interface.
- Used by on-chip test/control logic and by the verification harness to issue single and incrementing-burst reads and writes.
- Handles ack, err and (optionally) timeout, and reports completion status per command.

---
 rtl/wb_host_pkg.sv | 15 +
 rtl/wb_host_master.sv | 187 ++++++++++++++++++
 tb/tb_wb_host_master.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_host_pkg.sv
// Shared types and status encodings for the Wishbone host master.
package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REQ   = 2'd2,
        RSP   = 2'd3
    } state_e;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/wb_host_master.sv
// Wishbone classic initiator driven by a command / write-data / read-data
// stream interface. Issues single and incrementing-burst transfers and
// reports a per-command completion status.
// Optional macro WB_HOST_TIMEOUT_EN: abort a strobe that sees no ack/err
// within TIMEOUT cycles and report status TIMEOUT.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned LENW    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    input  logic [LENW-1:0] cmd_len_i,
    input  logic            wd_valid_i,
    output logic            wd_ready_o,
    input  logic [DW-1:0]   wd_data_i,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [DW-1:0]   rd_data_o,
    output logic            done_o,
    output logic [1:0]      status_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i
);

    localparam int unsigned SW       = DW / 8;
    localparam logic [AW-1:0] ADR_STEP = AW'(SW);

    state_e          state;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] beat_q;
    logic            last_beat;

`ifdef WB_HOST_TIMEOUT_EN
    localparam int unsigned TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]   to_cnt;
`endif

    // Current beat is the final one of the command.
    assign last_beat = (beat_q == len_q);

    // Command sequencer with registered Wishbone and stream outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            len_q       <= '0;
            beat_q      <= '0;
            cmd_ready_o <= 1'b0;
            wd_ready_o  <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            done_o      <= 1'b0;
            status_o    <= ST_OK;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
`ifdef WB_HOST_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ready_o && cmd_valid_i) begin
                        cmd_ready_o <= 1'b0;
                        wbm_we_o    <= cmd_we_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_sel_o   <= cmd_sel_i;
                        len_q       <= cmd_len_i;
                        beat_q      <= '0;
                        wbm_cyc_o   <= 1'b1;
                        if (cmd_we_i) begin
                            wd_ready_o <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            wbm_stb_o  <= 1'b1;
                            state      <= REQ;
`ifdef WB_HOST_TIMEOUT_EN
                            to_cnt     <= '0;
`endif
                        end
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end

                FETCH: begin
                    if (wd_ready_o && wd_valid_i) begin
                        wbm_dat_o  <= wd_data_i;
                        wd_ready_o <= 1'b0;
                        wbm_stb_o  <= 1'b1;
                        state      <= REQ;
`ifdef WB_HOST_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end

                REQ: begin
                    if (wbm_stb_o && wbm_err_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        done_o      <= 1'b1;
                        status_o    <= ST_ERR;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else if (wbm_stb_o && wbm_ack_i) begin
                        wbm_stb_o <= 1'b0;
                        if (!wbm_we_o) begin
                            rd_data_o  <= wbm_dat_i;
                            rd_valid_o <= 1'b1;
                            state      <= RSP;
                        end else if (last_beat) begin
                            wbm_cyc_o   <= 1'b0;
                            done_o      <= 1'b1;
                            status_o    <= ST_OK;
                            cmd_ready_o <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            wbm_adr_o  <= wbm_adr_o + ADR_STEP;
                            beat_q     <= beat_q + LENW'(1);
                            wd_ready_o <= 1'b1;
                            state      <= FETCH;
                        end
                    end
`ifdef WB_HOST_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        done_o      <= 1'b1;
                        status_o    <= ST_TIMEOUT;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
`endif
                end

                RSP: begin
                    if (rd_valid_o && rd_ready_i) begin
                        rd_valid_o <= 1'b0;
                        if (last_beat) begin
                            wbm_cyc_o   <= 1'b0;
                            done_o      <= 1'b1;
                            status_o    <= ST_OK;
                            cmd_ready_o <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            wbm_adr_o <= wbm_adr_o + ADR_STEP;
                            beat_q    <= beat_q + LENW'(1);
                            wbm_stb_o <= 1'b1;
                            state     <= REQ;
`ifdef WB_HOST_TIMEOUT_EN
                            to_cnt    <= '0;
`endif
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboard bench for wb_host_master: directed commands push expected bus
// beats, read words and completion statuses; a negedge monitor pops them.
module tb_wb_host_master;
    import wb_host_pkg::*;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned LENW    = 8;
    localparam int unsigned TIMEOUT = 16;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [3:0]      cmd_sel;
    logic [LENW-1:0] cmd_len;
    logic            wd_valid, wd_ready;
    logic [DW-1:0]   wd_data;
    logic            rd_valid, rd_ready;
    logic [DW-1:0]   rd_data;
    logic            done;
    logic [1:0]      status;
    logic            cyc, stb, we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_o, dat_i;
    logic [3:0]      sel;
    logic            ack, err;

    wb_host_master #(.AW(AW), .DW(DW), .LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len),
        .wd_valid_i(wd_valid), .wd_ready_o(wd_ready), .wd_data_i(wd_data),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .done_o(done), .status_o(status),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
        .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_dat_i(dat_i),
        .wbm_ack_i(ack), .wbm_err_i(err)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    logic [1:0]  exp_done[$];
    logic [31:0] wd_src[$];
    logic [31:0] rd_src[$];

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0, done_at = 0, wd_used = 0, cyc_drop = 0, cyc_cnt = 0;
    int slv_wait = 0, slv_beat = 0, slv_err_beat = -1, wait_cnt = 0;
    bit chk_cyc = 0, rd_toggle = 0, rd_hold = 0, slv_hang = 0, stray = 0, wd_hs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endfunction

    function automatic void push_bus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        bus_t e;
        e.adr = a; e.dat = d; e.we = w; e.sel = s;
        exp_bus.push_back(e);
    endfunction

    // Monitor, write-data source, read-data sink and Wishbone slave model.
    always @(negedge clk) begin
        bus_t        eb;
        logic [31:0] er;
        logic [1:0]  es;
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                done_at = cyc_cnt;
                chk_cyc = 0;
                if (exp_done.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL done_unexpected: got status %0d expected no completion", status);
                end else begin
                    es = exp_done.pop_front();
                    check("done_status", status, es);
                    check("done_cyc", cyc, 1'b0);
                end
            end else if (chk_cyc && !cyc) begin
                cyc_drop++;
            end

            if (wd_hs) begin
                void'(wd_src.pop_front());
                wd_used++;
            end
            wd_valid = (wd_src.size() > 0);
            wd_data  = wd_valid ? wd_src[0] : 32'h0;
            wd_hs    = wd_valid && wd_ready;

            rd_ready = rd_hold ? 1'b0 : (rd_toggle ? ~rd_ready : 1'b1);
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rd_unexpected: got %0h expected no read word", rd_data);
                end else begin
                    er = exp_rd.pop_front();
                    check("rd_data", rd_data, er);
                end
            end

            ack = 1'b0;
            err = 1'b0;
            if (stray) begin
                ack = 1'b1;
            end else if (stb && !slv_hang) begin
                if (wait_cnt < slv_wait) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    if (exp_bus.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL bus_unexpected: got adr %0h expected no beat", adr);
                    end else begin
                        eb = exp_bus.pop_front();
                        check("bus_beat", {adr, we, sel, (we ? dat_o : 32'h0)},
                              {eb.adr, eb.we, eb.sel, (eb.we ? eb.dat : 32'h0)});
                    end
                    if (slv_beat == slv_err_beat) begin
                        err = 1'b1;
                    end else begin
                        ack = 1'b1;
                        if (!we) dat_i = (rd_src.size() > 0) ? rd_src.pop_front() : 32'hBAD0BAD0;
                    end
                    slv_beat++;
                end
            end else begin
                wait_cnt = 0;
            end
        end else begin
            wd_hs = 0; ack = 1'b0; err = 1'b0; wait_cnt = 0;
        end
    end

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [7:0] l);
        bit acc;
        bit ok;
        cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_len = l; cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            acc = cmd_ready;
            @(negedge clk);
            if (acc) begin ok = 1; break; end
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL cmd_accept: got no cmd_ready expected acceptance within 50 cycles");
        end
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start) return;
        end
        vectors++; miscompares++;
        $display("FAIL done_wait: got no done expected done within %0d cycles", budget);
    endtask

    initial begin
        int t0;
        bit seen;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0; dat_i = '0; ack = 1'b0; err = 1'b0;

        // Reset values
        #12;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_cyc_stb", {cyc, stb}, 2'b00);
        check("rst_adr", adr, 32'h0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_done_status", {done, status}, 3'b000);
        check("rst_wd_ready", wd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Single write, one wait state
        wd_src.push_back(32'hDEADBEEF);
        slv_wait = 1; slv_beat = 0; slv_err_beat = -1;
        push_bus(32'h3000_0000, 32'hDEADBEEF, 1'b1, 4'hF);
        exp_done.push_back(ST_OK);
        send_cmd(1'b1, 32'h3000_0000, 4'hF, 8'd0);
        wait_done(50);

        // Read burst of four, rd_ready toggling
        slv_wait = 0; slv_beat = 0; rd_toggle = 1; cyc_drop = 0;
        for (int i = 0; i < 4; i++) begin
            rd_src.push_back(32'h10 + i);
            exp_rd.push_back(32'h10 + i);
            push_bus(32'h3000_0010 + 4 * i, 32'h0, 1'b0, 4'hF);
        end
        exp_done.push_back(ST_OK);
        send_cmd(1'b0, 32'h3000_0010, 4'hF, 8'd3);
        chk_cyc = 1;
        wait_done(100);
        check("burst_cyc_held", cyc_drop, 0);
        rd_toggle = 0;

        // Write burst aborted by err on second beat
        wd_used = 0; slv_beat = 0; slv_err_beat = 1;
        wd_src.push_back(32'hA0A0_0000);
        wd_src.push_back(32'hA1A1_0001);
        wd_src.push_back(32'hA2A2_0002);
        push_bus(32'h3000_0100, 32'hA0A0_0000, 1'b1, 4'hF);
        push_bus(32'h3000_0104, 32'hA1A1_0001, 1'b1, 4'hF);
        exp_done.push_back(ST_ERR);
        send_cmd(1'b1, 32'h3000_0100, 4'hF, 8'd2);
        wait_done(100);
        check("err_wd_consumed", wd_used, 2);
        check("err_wd_left", wd_src.size(), 1);
        check("err_cyc", cyc, 1'b0);
        slv_err_beat = -1;
        wd_src.delete();
        @(negedge clk);

        // Two-beat write, partial byte select
        slv_beat = 0;
        wd_src.push_back(32'h1111_1111);
        wd_src.push_back(32'h2222_2222);
        push_bus(32'h3000_0200, 32'h1111_1111, 1'b1, 4'h3);
        push_bus(32'h3000_0204, 32'h2222_2222, 1'b1, 4'h3);
        exp_done.push_back(ST_OK);
        send_cmd(1'b1, 32'h3000_0200, 4'h3, 8'd1);
        wait_done(100);

        // Address wrap at top of space
        slv_beat = 0;
        rd_src.push_back(32'h5555_AAAA);
        rd_src.push_back(32'h0123_4567);
        exp_rd.push_back(32'h5555_AAAA);
        exp_rd.push_back(32'h0123_4567);
        push_bus(32'hFFFF_FFFC, 32'h0, 1'b0, 4'hF);
        push_bus(32'h0000_0000, 32'h0, 1'b0, 4'hF);
        exp_done.push_back(ST_OK);
        send_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 8'd1);
        wait_done(100);

        // Stray ack while idle is ignored
        t0 = done_cnt;
        stray = 1;
        repeat (3) @(negedge clk);
        stray = 0;
        repeat (2) @(negedge clk);
        #1;
        check("stray_no_done", done_cnt - t0, 0);
        check("stray_cyc", cyc, 1'b0);

`ifdef WB_HOST_TIMEOUT_EN
        // Slave never responds
        slv_hang = 1;
        exp_done.push_back(ST_TIMEOUT);
        send_cmd(1'b0, 32'h3000_0080, 4'hF, 8'd0);
        t0 = cyc_cnt;
        check("timeout_stb", stb, 1'b1);
        wait_done(100);
        check("timeout_latency", done_at - t0, TIMEOUT);
        slv_hang = 0;
        @(negedge clk);
`endif

        // Async reset while a read word is held in RSP
        rd_hold = 1; slv_beat = 0;
        rd_src.push_back(32'h0000_0077);
        rd_src.push_back(32'h0000_0078);
        push_bus(32'h3000_0040, 32'h0, 1'b0, 4'hF);
        send_cmd(1'b0, 32'h3000_0040, 4'hF, 8'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (rd_valid) begin seen = 1; break; end
        end
        check("rsp_rd_valid_seen", seen, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd_valid", rd_valid, 1'b0);
        check("arst_cyc_stb", {cyc, stb}, 2'b00);
        check("arst_done", done, 1'b0);
        rd_src.delete();
        rd_hold = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        slv_beat = 0;
        rd_src.push_back(32'hCAFE_0001);
        exp_rd.push_back(32'hCAFE_0001);
        push_bus(32'h3000_0020, 32'h0, 1'b0, 4'hF);
        exp_done.push_back(ST_OK);
        send_cmd(1'b0, 32'h3000_0020, 4'hF, 8'd0);
        wait_done(50);

        // Everything expected was observed
        repeat (2) @(negedge clk);
        check("left_bus", exp_bus.size(), 0);
        check("left_rd", exp_rd.size(), 0);
        check("left_done", exp_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500000");
        $fatal(1);
    end

endmodule
